// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: board geometry, RGB332 colours,
// the arbiter state encoding and the RAM grant encoding.
package fb_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 20;
    localparam int FB_DEPTH = BOARD_W * BOARD_H;

    // RGB332 colours (RRRGGGBB)
    localparam logic [7:0] COL_BG    = 8'h00;
    localparam logic [7:0] COL_CLEAR = 8'h00;
    localparam logic [7:0] COL_I     = 8'h1F;  // cyan
    localparam logic [7:0] COL_O     = 8'hFC;  // yellow
    localparam logic [7:0] COL_T     = 8'h83;  // purple
    localparam logic [7:0] COL_S     = 8'h1C;  // green
    localparam logic [7:0] COL_Z     = 8'hE0;  // red
    localparam logic [7:0] COL_J     = 8'h03;  // blue
    localparam logic [7:0] COL_L     = 8'hF0;  // orange

    typedef enum logic {
        IDLE,
        CLEAR
    } arb_state_t;

    typedef enum logic [2:0] {
        G_NONE,
        G_DISP,
        G_CLR,
        G_WR,
        G_RD
    } grant_t;

endpackage

// File: rtl/fb_rr_arb.sv
// Two-requester round-robin arbiter for the game write and read ports.
// Grants are combinational; the pointer moves only when a grant is issued.
module fb_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    // 1 = read has priority on the next contended cycle (write was granted last)
    logic r_prio_rd;

    // Grant selection: single requester wins outright, contention uses the pointer
    always_comb begin
        o_gnt_wr = 1'b0;
        o_gnt_rd = 1'b0;
        if (i_en) begin
            if (i_req_wr && i_req_rd) begin
                o_gnt_rd = r_prio_rd;
                o_gnt_wr = !r_prio_rd;
            end else begin
                o_gnt_wr = i_req_wr;
                o_gnt_rd = i_req_rd;
            end
        end
    end

    // Pointer update: favour the port that was not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_rd <= 1'b0;
        end else if (o_gnt_wr) begin
            r_prio_rd <= 1'b1;
        end else if (o_gnt_rd) begin
            r_prio_rd <= 1'b0;
        end
    end

endmodule

// File: rtl/cell_fb_arbiter.sv
// Cell framebuffer RAM arbiter: display fetch (fixed latency, top priority),
// board-clear sweep, then round-robin game write/read ports.
module cell_fb_arbiter #(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = fb_pkg::FB_DEPTH,
    parameter int                ADDR_W      = 8,
    parameter logic [DATA_W-1:0] BG_COLOR    = fb_pkg::COL_BG,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = fb_pkg::COL_CLEAR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_color,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              oob_err
);

    import fb_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);

    arb_state_t        r_state, w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_next;
    logic              r_done, w_done_next;

    logic              w_disp_in, w_wr_in, w_rd_in, w_disp_hit;
    logic              w_arb_en, w_gnt_wr, w_gnt_rd;
    grant_t            w_grant;

    logic              r_disp_p1, r_disp_in_p1, r_disp_valid;
    logic [DATA_W-1:0] r_disp_color;
    logic              r_rd_p1, r_rd_in_p1, r_rd_data_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_oob_err;

    // Unsigned range checks; zero-extended so DEPTH up to 2**ADDR_W is safe
    assign w_disp_in  = {1'b0, disp_addr} < DEPTH_X;
    assign w_wr_in    = {1'b0, wr_addr}   < DEPTH_X;
    assign w_rd_in    = {1'b0, rd_addr}   < DEPTH_X;
    // An out-of-range display request leaves the RAM slot free
    assign w_disp_hit = disp_req && w_disp_in;
    // Game ports only see RAM cycles the display and sweep leave unused
    assign w_arb_en   = rst && (r_state == IDLE) && !w_disp_hit;

    fb_rr_arb u_rr_arb (
        .clk      (clk),
        .rst_n    (rst),
        .i_en     (w_arb_en),
        .i_req_wr (wr_valid),
        .i_req_rd (rd_valid),
        .o_gnt_wr (w_gnt_wr),
        .o_gnt_rd (w_gnt_rd)
    );

    // Grant priority and combinational RAM command
    always_comb begin
        w_grant   = G_NONE;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            w_grant = G_NONE;
        end else if (w_disp_hit) begin
            w_grant = G_DISP;
        end else if (r_state == CLEAR) begin
            w_grant = G_CLR;
        end else if (w_gnt_wr) begin
            w_grant = G_WR;
        end else if (w_gnt_rd) begin
            w_grant = G_RD;
        end
        case (w_grant)
            G_DISP: begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end
            G_CLR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_clr_cnt;
                ram_wdata = CLEAR_COLOR;
            end
            G_WR: begin
                ram_en    = w_wr_in;
                ram_we    = w_wr_in;
                ram_addr  = w_wr_in ? wr_addr : '0;
                ram_wdata = w_wr_in ? wr_data : '0;
            end
            G_RD: begin
                ram_en   = w_rd_in;
                ram_addr = w_rd_in ? rd_addr : '0;
            end
            default: ;
        endcase
    end

    // Sweep FSM next state: counter advances only on cycles the sweep owns
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_done_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_start) begin
                    w_state_next   = CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (w_grant == G_CLR) begin
                    if (r_clr_cnt == LAST_CELL) begin
                        w_state_next   = IDLE;
                        w_clr_cnt_next = '0;
                        w_done_next    = 1'b1;
                    end else begin
                        w_clr_cnt_next = r_clr_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Sweep FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_done    <= w_done_next;
        end
    end

    // Display pipeline: RAM data arrives at N+1, registered colour shows at N+2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp_p1    <= 1'b0;
            r_disp_in_p1 <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_color <= '0;
        end else begin
            r_disp_p1    <= disp_req;
            r_disp_in_p1 <= w_disp_in;
            r_disp_valid <= r_disp_p1;
            if (r_disp_p1) begin
                r_disp_color <= r_disp_in_p1 ? ram_rdata : BG_COLOR;
            end
        end
    end

    // Game read pipeline and sticky out-of-range flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_p1         <= 1'b0;
            r_rd_in_p1      <= 1'b0;
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
            r_oob_err       <= 1'b0;
        end else begin
            r_rd_p1         <= w_gnt_rd;
            r_rd_in_p1      <= w_rd_in;
            r_rd_data_valid <= r_rd_p1;
            if (r_rd_p1) begin
                r_rd_data <= r_rd_in_p1 ? ram_rdata : '0;
            end
            if ((w_gnt_wr && !w_wr_in) || (w_gnt_rd && !w_rd_in)) begin
                r_oob_err <= 1'b1;
            end
        end
    end

    assign wr_ready      = w_gnt_wr;
    assign rd_ready      = w_gnt_rd;
    assign disp_valid    = r_disp_valid;
    assign disp_color    = r_disp_color;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_data       = r_rd_data;
    assign clear_busy    = (r_state == CLEAR);
    assign clear_done    = r_done;
    assign oob_err       = r_oob_err;

endmodule

// File: tb/tb_cell_fb_arbiter.sv
// Directed bench for cell_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_cell_fb_arbiter;

    logic       clk, rst;
    logic       disp_req;
    logic [7:0] disp_addr;
    logic       disp_valid;
    logic [7:0] disp_color;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_addr, wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_addr;
    logic       rd_data_valid;
    logic [7:0] rd_data;
    logic       clear_start, clear_busy, clear_done;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       oob_err;

    logic       ram_init;
    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    cell_fb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_valid    (disp_valid),
        .disp_color    (disp_color),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .oob_err       (oob_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM, registered read; preloaded with 8'hAA
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hAA;
            ram_rdata <= 8'h00;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt, done_cnt, first_busy, done_at, wr_rdy_busy, bad_cells, rdy_miss, done_seen;
        rst = 1'b0; ram_init = 1'b1;
        disp_req = 0; disp_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
        rd_valid = 0; rd_addr = 0; clear_start = 0;
        repeat (2) @(negedge clk);
        ram_init = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // ---- reset in the middle of a sweep with traffic present ----
        clear_start = 1; @(negedge clk); clear_start = 0;
        repeat (4) @(negedge clk);
        chk("busy_before_reset", clear_busy, 1);
        disp_req = 1; disp_addr = 9; wr_valid = 1; wr_addr = 7; rd_valid = 1; rd_addr = 7;
        #1 rst = 1'b0; #1;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_rd_data_valid", rd_data_valid, 0);
        chk("rst_oob_err", oob_err, 0);
        @(negedge clk);
        disp_req = 0; wr_valid = 0; rd_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1 done_seen += (clear_done | clear_busy) ? 1 : 0;
            @(negedge clk);
        end
        chk("abort_no_done_no_busy", done_seen, 0);

        // ---- first contended grant goes to write (writes E0 to cell 5) ----
        wr_valid = 1; wr_addr = 5; wr_data = 8'hE0; rd_valid = 1; rd_addr = 9; #1;
        chk("first_grant_wr_ready", wr_ready, 1);
        chk("first_grant_rd_ready", rd_ready, 0);
        chk("first_grant_ram_we", ram_we, 1);
        chk("first_grant_ram_addr", ram_addr, 5);
        chk("first_grant_ram_wdata", ram_wdata, 8'hE0);
        @(negedge clk);
        wr_valid = 0; #1;
        chk("read9_rd_ready", rd_ready, 1);
        chk("read9_ram_we", ram_we, 0);
        @(negedge clk);
        rd_valid = 0; #1;
        chk("read9_not_yet_valid", rd_data_valid, 0);
        @(negedge clk); #1;
        chk("read9_valid", rd_data_valid, 1);
        chk("read9_data", rd_data, 8'hAA);
        @(negedge clk);

        // ---- display fetch of cell 5 ----
        disp_req = 1; disp_addr = 5; #1;
        chk("disp_ram_en", ram_en, 1);
        chk("disp_ram_addr", ram_addr, 5);
        @(negedge clk);
        disp_req = 0; #1;
        chk("disp_n1_valid", disp_valid, 0);
        @(negedge clk); #1;
        chk("disp_n2_valid", disp_valid, 1);
        chk("disp_n2_color", disp_color, 8'hE0);
        @(negedge clk); #1;
        chk("disp_n3_valid", disp_valid, 0);
        chk("disp_n3_color_held", disp_color, 8'hE0);
        @(negedge clk);

        // ---- collision: display beats the write, write goes next cycle ----
        disp_req = 1; disp_addr = 5; wr_valid = 1; wr_addr = 7; wr_data = 8'h1C; #1;
        chk("coll_wr_ready_blocked", wr_ready, 0);
        chk("coll_ram_addr_disp", ram_addr, 5);
        @(negedge clk);
        disp_req = 0; #1;
        chk("coll_wr_ready_next", wr_ready, 1);
        chk("coll_ram_we", ram_we, 1);
        chk("coll_ram_addr", ram_addr, 7);
        @(negedge clk);
        wr_valid = 0; rd_valid = 1; rd_addr = 7; #1;
        chk("coll_read_ready", rd_ready, 1);
        @(negedge clk);
        rd_valid = 0;
        @(negedge clk); #1;
        chk("coll_read_valid", rd_data_valid, 1);
        chk("coll_read_data", rd_data, 8'h1C);
        @(negedge clk);

        // ---- round robin: last game grant was a read, so write leads ----
        wr_addr = 10; wr_data = 8'h03; rd_addr = 11;
        for (int i = 0; i < 6; i++) begin
            wr_valid = (i < 4); rd_valid = (i < 4); #1;
            if (i < 4) begin
                chk($sformatf("rr%0d_wr_ready", i), wr_ready, (i % 2 == 0) ? 1 : 0);
                chk($sformatf("rr%0d_rd_ready", i), rd_ready, (i % 2 == 1) ? 1 : 0);
            end
            chk($sformatf("rr%0d_rd_data_valid", i), rd_data_valid,
                (i >= 2 && i % 2 == 1) ? 1 : 0);
            @(negedge clk);
        end
        wr_valid = 0; rd_valid = 0;

        // ---- clear sweep with the display stealing every 4th cycle ----
        clear_start = 1; #1;
        chk("clr_start_busy_low", clear_busy, 0);
        @(negedge clk);
        clear_start = 0;
        busy_cnt = 0; done_cnt = 0; first_busy = -1; done_at = -1; wr_rdy_busy = 0;
        for (int j = 0; j < 300; j++) begin
            disp_req = (j % 4 == 0); disp_addr = 5;
            wr_valid = 1; wr_addr = 20; wr_data = 8'h00; #1;
            if (clear_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = j;
                if (wr_ready) wr_rdy_busy++;
            end
            if (clear_done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            @(negedge clk);
        end
        disp_req = 0; wr_valid = 0;
        chk("clr_first_busy_cycle", first_busy, 0);
        chk("clr_busy_cycles", busy_cnt, 267);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_done_cycle", done_at, 267);
        chk("clr_wr_ready_while_busy", wr_rdy_busy, 0);
        @(negedge clk);

        // ---- read back the whole board ----
        bad_cells = 0; rdy_miss = 0;
        for (int a = 0; a < 202; a++) begin
            rd_valid = (a < 200); rd_addr = 8'(a); #1;
            if (a < 200 && !rd_ready) rdy_miss++;
            if (a >= 2 && !(rd_data_valid === 1'b1 && rd_data === 8'h00)) bad_cells++;
            @(negedge clk);
        end
        rd_valid = 0;
        chk("readback_ready_misses", rdy_miss, 0);
        chk("readback_bad_cells", bad_cells, 0);

        // ---- in-range display of a fresh value so BG is distinguishable ----
        wr_valid = 1; wr_addr = 10; wr_data = 8'h5A; @(negedge clk);
        wr_valid = 0; disp_req = 1; disp_addr = 10; @(negedge clk);
        disp_req = 0; @(negedge clk); #1;
        chk("disp10_color", disp_color, 8'h5A);
        @(negedge clk);

        // ---- out-of-range write ----
        wr_valid = 1; wr_addr = 200; wr_data = 8'h77; #1;
        chk("oob_wr_ready", wr_ready, 1);
        chk("oob_wr_ram_en", ram_en, 0);
        chk("oob_wr_ram_we", ram_we, 0);
        chk("oob_err_before", oob_err, 0);
        @(negedge clk);
        wr_valid = 0; #1;
        chk("oob_err_set", oob_err, 1);
        @(negedge clk);

        // ---- out-of-range display; next cycle its free slot serves a read ----
        disp_req = 1; disp_addr = 255; #1;
        chk("oob_disp_ram_en", ram_en, 0);
        @(negedge clk);
        disp_addr = 250; rd_valid = 1; rd_addr = 3; #1;
        chk("oob_disp_free_rd_ready", rd_ready, 1);
        chk("oob_disp_free_ram_addr", ram_addr, 3);
        @(negedge clk);
        disp_req = 0; rd_valid = 0; #1;
        chk("oob_disp_valid", disp_valid, 1);
        chk("oob_disp_color", disp_color, 8'h00);
        @(negedge clk); #1;
        chk("oob_disp2_valid", disp_valid, 1);
        chk("free_slot_rd_valid", rd_data_valid, 1);
        chk("free_slot_rd_data", rd_data, 8'h00);
        @(negedge clk);

        // ---- out-of-range read returns zero, no RAM access ----
        rd_valid = 1; rd_addr = 250; #1;
        chk("oob_rd_ready", rd_ready, 1);
        chk("oob_rd_ram_en", ram_en, 0);
        @(negedge clk);
        rd_valid = 0;
        @(negedge clk); #1;
        chk("oob_rd_valid", rd_data_valid, 1);
        chk("oob_rd_data", rd_data, 8'h00);
        chk("oob_err_sticky", oob_err, 1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cell_fb_arbiter.md
Name: cell_fb_arbiter

Overview:
Owns the single-port cell framebuffer RAM (10x20 Tetris board, one colour byte per cell) and shares it between three users: the display pixel-fetch path, the game-logic read and write ports, and an internal board-clear sweeper. The display path has fixed latency and absolute priority so it always meets pixel timing. The two game ports share the remaining RAM cycles round-robin. It sits between the game engine and the VGA pixel path, and its disp_color output feeds the VGA controller's rgb_8 input.

Parameters:
DATA_W, 8, colour width (RGB332)
DEPTH, 200, number of cells
ADDR_W, 8, address width
BG_COLOR, 8'h00, colour returned for out-of-range display addresses
CLEAR_COLOR, 8'h00, value written by the clear sweep

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
disp_req  in  1  display fetch request, single-cycle, no backpressure
disp_addr  in  ADDR_W  display cell address
disp_valid  out  1  display data valid pulse
disp_color  out  DATA_W  fetched colour, held between pulses
wr_valid  in  1  game write request
wr_ready  out  1  game write accepted
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_valid  in  1  game read request
rd_ready  out  1  game read accepted
rd_addr  in  ADDR_W  read address
rd_data_valid  out  1  read data valid pulse
rd_data  out  DATA_W  read data, held between pulses
clear_start  in  1  start board clear (pulse)
clear_busy  out  1  clear sweep in progress
clear_done  out  1  one-cycle pulse at sweep end
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read
oob_err  out  1  sticky out-of-range game access flag

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, clear counter 0, RR pointer favours write. RAM contents are untouched. A reset during a clear aborts the sweep and does not pulse clear_done.
- States: IDLE and CLEAR. IDLE to CLEAR on clear_start. CLEAR to IDLE after the write to address DEPTH-1. clear_start during CLEAR is ignored.
- Per-cycle priority: display, then clear sweep, then game (round-robin).
- RAM outputs (ram_en, ram_we, ram_addr, ram_wdata) are combinational from the grant. ram_en is 0 in any cycle with no grant.
- Display path:
  - disp_req in cycle N always wins.
  - disp_valid=1 in cycle N+2 with registered disp_color.
  - If disp_addr >= DEPTH: no RAM access, disp_color=BG_COLOR at N+2, and the RAM slot is free for other users.
  - Back-to-back disp_req every cycle is legal. The game and clear paths then stall; the pixel rate is about 1 request per 20 clocks.
- Game ports:
  - wr_ready and rd_ready are combinational and may depend on valid. A transfer occurs on valid && ready.
  - Requesters hold address and data stable until the transfer.
  - Both ready signals are 0 during CLEAR or when disp_req uses the RAM.
  - If both valid, grant the port not granted last. If only one is valid, grant it. The pointer updates only on a game grant.
  - Reads: rd_data_valid at N+2 after the accept cycle N.
- Out-of-range game access (addr >= DEPTH):
  - Accepted under normal arbitration, with no RAM access.
  - A write is dropped. A read returns 0 at N+2.
  - oob_err sets and stays set until reset.
- Clear sweep:
  - Writes CLEAR_COLOR to addresses 0..DEPTH-1, one per cycle not taken by the display. The counter holds when the display steals a cycle.
  - clear_busy is high from the cycle after clear_start until the cycle after the last write. clear_done pulses in the cycle clear_busy falls.
- Width rules: address compares against DEPTH are unsigned. The clear counter is ADDR_W bits and never wraps past DEPTH-1.

Decomposition:
- Shared package fb_pkg holds:
  - BOARD_W=10, BOARD_H=20, DEPTH=BOARD_W*BOARD_H
  - the RGB332 colour constants (BG, CLEAR, the piece colours)
  - the arbiter state enum {IDLE, CLEAR}
  - the grant encoding {G_NONE, G_DISP, G_CLR, G_WR, G_RD}
- One sub-module, fb_rr_arb: the 2-requester round-robin with pointer register and grant outputs.

Test Plan:
- Reset: hold rst=0 mid-activity, release -> all outputs 0, ram_en=0, oob_err=0; first contended game grant goes to write.
- Display fetch: write 8'hE0 to addr 5, then disp_req addr 5 in cycle N -> disp_valid=1 and disp_color=8'hE0 in N+2 only; disp_color still 8'hE0 at N+3.
- Collision: disp_req and wr_valid (addr 7, data 8'h1C) in the same cycle -> wr_ready=0 that cycle, =1 next cycle with ram_we=1, ram_addr=7; a later read of 7 returns 8'h1C.
- Round-robin: wr_valid and rd_valid held high with no display traffic -> grants alternate wr, rd, wr, rd; rd_data_valid follows each rd grant by 2 cycles.
- Clear: clear_start with disp_req every 4th cycle -> clear_busy high for 200 + stolen cycles, wr_ready=0 throughout, single clear_done pulse; all 200 cells then read 8'h00.
- Out-of-range: write addr 200 -> accepted, ram_we=0, oob_err=1; disp_req addr 255 -> disp_color=BG_COLOR at N+2 and ram_en=0 in cycle N.
